// File: rtl/run_job_arbiter.sv
// Round-robin arbiter that hands one shared run engine to NREQ requesters, counts each job's
// RUN cycles up to its requested length and reports the result on a valid/ready port.
module run_job_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned CW   = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ*CW-1:0] req_len_i,
  input  logic               abort_i,
  output logic               done_valid_o,
  input  logic               done_ready_i,
  output logic [IDW-1:0]     done_id_o,
  output logic [DW-1:0]      done_data_o,
  output logic [CW-1:0]      done_count_o,
  output logic               done_aborted_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StInit = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] job_id_q, job_id_d;
  logic [DW-1:0]  job_data_q, job_data_d;
  logic [CW-1:0]  job_len_q, job_len_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic [DW-1:0]  done_data_q, done_data_d;
  logic [CW-1:0]  done_count_q, done_count_d;
  logic           done_aborted_q, done_aborted_d;

  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rr_ptr_q       <= '0;
      job_id_q       <= '0;
      job_data_q     <= '0;
      job_len_q      <= '0;
      done_id_q      <= '0;
      done_data_q    <= '0;
      done_count_q   <= '0;
      done_aborted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      job_id_q       <= job_id_d;
      job_data_q     <= job_data_d;
      job_len_q      <= job_len_d;
      done_id_q      <= done_id_d;
      done_data_q    <= done_data_d;
      done_count_q   <= done_count_d;
      done_aborted_q <= done_aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (grant_found) state_d = StInit;
      StInit: state_d = abort_i ? StDone : StRun;
      StRun:  if (abort_i || (cnt_q == job_len_q)) state_d = StDone;
      StDone: if (done_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d          = cnt_q;
    rr_ptr_d       = rr_ptr_q;
    job_id_d       = job_id_q;
    job_data_d     = job_data_q;
    job_len_d      = job_len_q;
    done_id_d      = done_id_q;
    done_data_d    = done_data_q;
    done_count_d   = done_count_q;
    done_aborted_d = done_aborted_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          job_id_d   = grant_id;
          job_data_d = req_data_i[32'(grant_id) * DW +: DW];
          job_len_d  = req_len_i[32'(grant_id) * CW +: CW];
        end
      end
      StInit: if (!abort_i) cnt_d = '0;
      StRun:  if (!abort_i && (cnt_q != job_len_q)) cnt_d = cnt_q + CW'(1);
      StDone: begin
        if (done_ready_i) begin
          rr_ptr_d = (32'(job_id_q) == NREQ - 1) ? '0 : job_id_q + IDW'(1);
        end
      end
      default: ;
    endcase
    // Completion fields are latched on entry to DONE so they survive the next job's counting.
    if ((state_q == StInit || state_q == StRun) && state_d == StDone) begin
      done_id_d      = job_id_q;
      done_data_d    = job_data_q;
      done_count_d   = cnt_q;
      done_aborted_d = abort_i;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && grant_found) req_ready_o[grant_id] = 1'b1;
    busy_o       = (state_q != StIdle);
    done_valid_o = (state_q == StDone);
  end

  assign done_id_o      = done_id_q;
  assign done_data_o    = done_data_q;
  assign done_count_o   = done_count_q;
  assign done_aborted_o = done_aborted_q;

endmodule

// File: tb/tb_run_job_arbiter.sv
// Bench for run_job_arbiter: directed scenarios followed by random traffic, every cycle checked
// against a job-level model that tracks time elapsed since each grant.
module tb_run_job_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 3;
  localparam int unsigned IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*CW-1:0] req_len;
  logic               abort;
  logic               done_valid;
  logic               done_ready;
  logic [IDW-1:0]     done_id;
  logic [DW-1:0]      done_data;
  logic [CW-1:0]      done_count;
  logic               done_aborted;
  logic               busy;

  logic [DW-1:0] rd [NREQ];
  logic [CW-1:0] rl [NREQ];

  // Model: a job is in flight for m_t cycles after its grant (1 = INIT, >=2 = RUN at count m_t-2).
  int          m_ptr, m_t, m_jid, m_jlen, m_last, granted;
  bit          m_active, m_done, hold;
  logic [DW-1:0] m_jdata;
  int          e_id, e_count;
  logic [DW-1:0] e_data;
  bit          e_ab;
  int          n_vec, n_err;

  run_job_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .IDW(IDW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_data_i     (req_data),
    .req_len_i      (req_len),
    .abort_i        (abort),
    .done_valid_o   (done_valid),
    .done_ready_i   (done_ready),
    .done_id_o      (done_id),
    .done_data_o    (done_data),
    .done_count_o   (done_count),
    .done_aborted_o (done_aborted),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = rd[i];
      req_len[i*CW +: CW]  = rl[i];
    end
  end

  function automatic int rr_pick();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % int'(NREQ);
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_t = 0; m_jid = 0; m_jlen = 0; m_last = 0; m_jdata = '0;
    m_active = 1'b0; m_done = 1'b0;
    e_id = 0; e_count = 0; e_data = '0; e_ab = 1'b0;
  endtask

  task automatic finish_job(input bit ab, input int cnt);
    m_active = 1'b0; m_done = 1'b1;
    e_id = m_jid; e_data = m_jdata; e_count = cnt; e_ab = ab; m_last = cnt;
  endtask

  task automatic model_edge();
    int g;
    granted = -1;
    if (m_done) begin
      if (done_ready) begin
        m_done = 1'b0;
        m_ptr  = (m_jid + 1) % int'(NREQ);
      end
    end else if (m_active) begin
      if (abort) finish_job(1'b1, (m_t == 1) ? m_last : m_t - 2);
      else if (m_t >= 2 && m_t - 2 == m_jlen) finish_job(1'b0, m_jlen);
      else m_t++;
    end else begin
      g = rr_pick();
      if (g >= 0) begin
        m_active = 1'b1; m_t = 1; m_jid = g; m_jdata = rd[g]; m_jlen = int'(rl[g]);
        granted = g;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] er;
    int p;
    er = '0;
    p  = rr_pick();
    if (!m_active && !m_done && p >= 0) er[p] = 1'b1;
    cmp("req_ready", 64'(req_ready), 64'(er));
    cmp("busy", 64'(busy), 64'(m_active || m_done));
    cmp("done_valid", 64'(done_valid), 64'(m_done));
    cmp("done_id", 64'(done_id), 64'(e_id));
    cmp("done_data", 64'(done_data), 64'(e_data));
    cmp("done_count", 64'(done_count), 64'(e_count));
    cmp("done_aborted", 64'(done_aborted), 64'(e_ab));
  endtask

  // Called one time unit after a rising edge with this cycle's inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    if (granted >= 0 && !hold) begin
      req_valid[granted] = 1'b0;
      rd[granted] = $urandom;  // post-grant changes must not reach the running job
      rl[granted] = CW'($urandom);
    end
  endtask

  task automatic raise(input int i, input logic [DW-1:0] d, input int len);
    req_valid[i] = 1'b1;
    rd[i] = d;
    rl[i] = CW'(len);
  endtask

  initial begin
    n_vec = 0; n_err = 0; hold = 1'b0; granted = -1;
    rst_n = 1'b0; req_valid = '0; abort = 1'b0; done_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rd[i] = '0; rl[i] = '0; end
    model_reset();
    #3;
    check_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single job, length 5.
    done_ready = 1'b1;
    raise(0, 32'hCAFE_0000, 5);
    for (int c = 0; c < 12; c++) step();

    // Four requesters held valid with zero length: rotating grants, one idle cycle between jobs.
    hold = 1'b1;
    for (int i = 0; i < NREQ; i++) raise(i, 32'h1000_0000 + i, 0);
    for (int c = 0; c < 21; c++) step();
    hold = 1'b0;
    req_valid = '0;
    step();

    // Maximum length, no wrap.
    raise(1, 32'h7777_0001, 7);
    for (int c = 0; c < 13; c++) step();

    // Abort at count 2 of a length-6 job, then abort while idle.
    raise(2, 32'hAB0A_0002, 6);
    for (int c = 0; c < 12; c++) begin
      abort = (m_active && m_t == 4);
      step();
    end
    abort = 1'b1;
    for (int c = 0; c < 3; c++) step();
    abort = 1'b0;

    // Consumer stall in DONE with another request pending.
    done_ready = 1'b0;
    raise(0, 32'h5151_0000, 1);
    for (int c = 0; c < 8; c++) step();
    raise(1, 32'h5151_0001, 2);
    for (int c = 0; c < 10; c++) step();
    done_ready = 1'b1;
    for (int c = 0; c < 9; c++) step();

    // Reset while RUN at count 3, then requester 0 regains priority.
    raise(2, 32'hDEAD_0002, 7);
    for (int c = 0; c < 15; c++) begin
      if (m_active && m_t == 5) break;
      step();
    end
    rst_n = 1'b0; req_valid = '0; abort = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) raise(i, 32'h0F0F_0000 + i, i);
    for (int c = 0; c < 10; c++) step();

    // Random traffic with periodic consumer stalls and sparse aborts.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0) raise(i, $urandom, int'($urandom_range(7)));
      end
      abort      = ($urandom_range(15) == 0);
      done_ready = (c % 100 < 20) ? 1'b0 : ($urandom_range(1) == 1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
